matrix_load_sequencer: RTL

//  Synthesizable loader for data_path. Takes one command stream and drives the weight, input, label and code write ports,

---
 rtl/matrix_load_pkg.sv | 38 +++
 rtl/load_channel.sv | 57 +++++
 rtl/matrix_load_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_load_pkg.sv
// Shared types for the matrix load sequencer: command opcodes, write channels,
// sequencer FSM states and the matrix word width helper.
package matrix_load_pkg;

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_WR_WEIGHT  = 3'd1,
        OP_WR_INPUT   = 3'd2,
        OP_WR_LABEL   = 3'd3,
        OP_WR_CODE    = 3'd4,
        OP_UPD_WEIGHT = 3'd5,
        OP_START      = 3'd6,
        OP_STOP       = 3'd7
    } cmd_op_e;

    // Channel order also fixes the order of the matrix channel instances.
    typedef enum logic [2:0] {
        CH_W = 3'd0,
        CH_I = 3'd1,
        CH_L = 3'd2,
        CH_U = 3'd3,
        CH_C = 3'd4
    } chan_e;

    localparam int unsigned NUM_CH = 5;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_LRST = 2'd1,
        S_ARM  = 2'd2,
        S_RUN  = 2'd3
    } state_e;

    function automatic int unsigned calc_data_w(input int unsigned elem_w, input int unsigned num_lanes);
        return elem_w * num_lanes;
    endfunction

endpackage

// File: rtl/load_channel.sv
// One write channel: holds payload and row of the last write, emits a one-cycle
// strobe after each write, and keeps the auto row counter (last row used + 1).
module load_channel #(
    parameter int unsigned PAY_W = 8,
    parameter int unsigned IDX_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic             auto_i,
    input  logic [IDX_W-1:0] row_i,
    input  logic [PAY_W-1:0] pay_i,
    output logic [PAY_W-1:0] pay_o,
    output logic [IDX_W-1:0] row_o,
    output logic             strobe_o
);

    logic [PAY_W-1:0] pay_q, pay_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             stb_q, stb_d;
    logic [IDX_W-1:0] row_sel;

    // Next-state: capture on write, counter follows the row actually used.
    always_comb begin
        pay_d   = pay_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        stb_d   = wr_en_i;
        row_sel = auto_i ? cnt_q : row_i;
        if (wr_en_i) begin
            pay_d = pay_i;
            row_d = row_sel;
            cnt_d = row_sel + IDX_W'(1);
        end
    end

    // Channel registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pay_q <= '0;
            row_q <= '0;
            cnt_q <= '0;
            stb_q <= 1'b0;
        end else begin
            pay_q <= pay_d;
            row_q <= row_d;
            cnt_q <= cnt_d;
            stb_q <= stb_d;
        end
    end

    assign pay_o    = pay_q;
    assign row_o    = row_q;
    assign strobe_o = stb_q;

endmodule

// File: rtl/matrix_load_sequencer.sv
// Command-stream loader for data_path: drives weight/input/label/update/code
// write ports, then the locator-reset -> code-enable -> controller-enable start.
// Optional build macro LOADER_STATS_EN adds saturating per-op counters.
module matrix_load_sequencer
    import matrix_load_pkg::*;
#(
    parameter int unsigned ELEM_W     = 16,
    parameter int unsigned NUM_LANES  = 3,
    parameter int unsigned IDX_W      = 32,
    parameter int unsigned CODE_W     = 12,
    parameter int unsigned RUN_CYCLES = 0,
    localparam int unsigned DATA_W    = calc_data_w(ELEM_W, NUM_LANES)
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic              cmd_auto_row,
    input  logic [IDX_W-1:0]  cmd_layer,
    input  logic [IDX_W-1:0]  cmd_row,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] w_wr_data,
    output logic [IDX_W-1:0]  w_wr_layer,
    output logic [IDX_W-1:0]  w_wr_row,
    output logic              w_is_write,
    output logic [DATA_W-1:0] i_wr_data,
    output logic [IDX_W-1:0]  i_wr_layer,
    output logic [IDX_W-1:0]  i_wr_row,
    output logic              i_is_write,
    output logic [DATA_W-1:0] l_wr_data,
    output logic [IDX_W-1:0]  l_wr_layer,
    output logic [IDX_W-1:0]  l_wr_row,
    output logic              l_is_write,
    output logic [DATA_W-1:0] u_dc_dw,
    output logic [IDX_W-1:0]  u_layer,
    output logic [IDX_W-1:0]  u_row,
    output logic              u_is_update,
    output logic [IDX_W-1:0]  code_write_line,
    output logic [CODE_W-1:0] code_write_data,
    output logic              code_is_write,
    output logic              locator_reset,
    output logic              code_enable,
    output logic              ctrl_enable,
    output logic              run_done,
`ifdef LOADER_STATS_EN
    output logic [IDX_W-1:0]  stat_w,
    output logic [IDX_W-1:0]  stat_i,
    output logic [IDX_W-1:0]  stat_l,
    output logic [IDX_W-1:0]  stat_u,
    output logic [IDX_W-1:0]  stat_c,
`endif
    output logic              cmd_err
);

    localparam int unsigned RUN_W = 32;
    localparam int unsigned MAT_W = IDX_W + DATA_W;

    state_e            state_q, state_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic              lrst_q, lrst_d;
    logic              code_en_q, code_en_d;
    logic              ctrl_en_q, ctrl_en_d;
    logic              done_q, done_d;
    logic [NUM_CH-1:0] wr_en;
    logic              accept;
    logic              run_expire;
    cmd_op_e           op;

    assign accept     = cmd_valid & ready_q;
    assign op         = cmd_op_e'(cmd_op);
    assign run_expire = (RUN_CYCLES != 0) && (state_q == S_RUN) &&
                        (run_cnt_q == RUN_W'(RUN_CYCLES - 1));

    // Next-state, channel write decode and registered-output targets.
    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        err_d     = err_q;
        wr_en     = '0;
        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    case (op)
                        OP_WR_WEIGHT:  wr_en[CH_W] = 1'b1;
                        OP_WR_INPUT:   wr_en[CH_I] = 1'b1;
                        OP_WR_LABEL:   wr_en[CH_L] = 1'b1;
                        OP_UPD_WEIGHT: wr_en[CH_U] = 1'b1;
                        OP_WR_CODE:    wr_en[CH_C] = 1'b1;
                        OP_START:      state_d     = S_LRST;
                        OP_STOP:       err_d       = 1'b1;
                        default:       ;
                    endcase
                end
            end
            S_LRST: state_d = S_ARM;
            S_ARM: begin
                state_d   = S_RUN;
                run_cnt_d = '0;
            end
            S_RUN: begin
                run_cnt_d = run_cnt_q + RUN_W'(1);
                if (accept && (op != OP_NOP) && (op != OP_STOP)) begin
                    err_d = 1'b1;
                end
                // STOP and expiry together still leave only once.
                if ((accept && (op == OP_STOP)) || run_expire) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
        ready_d   = (state_d == S_LOAD) || (state_d == S_RUN);
        lrst_d    = (state_d == S_LRST);
        code_en_d = (state_d == S_ARM) || (state_d == S_RUN);
        ctrl_en_d = (state_d == S_RUN);
        done_d    = (state_q == S_RUN) && (state_d == S_LOAD);
    end

    // State and control output registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q   <= S_LOAD;
            run_cnt_q <= '0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
            lrst_q    <= 1'b0;
            code_en_q <= 1'b0;
            ctrl_en_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            lrst_q    <= lrst_d;
            code_en_q <= code_en_d;
            ctrl_en_q <= ctrl_en_d;
            done_q    <= done_d;
        end
    end

    assign cmd_ready     = ready_q;
    assign locator_reset = lrst_q;
    assign code_enable   = code_en_q;
    assign ctrl_enable   = ctrl_en_q;
    assign run_done      = done_q;
    assign cmd_err       = err_q;

    // Matrix channels carry {layer, data}; index order is w, i, l, u.
    logic [MAT_W-1:0] mat_pay [4];
    logic [IDX_W-1:0] mat_row [4];
    logic [3:0]       mat_stb;

    for (genvar g = 0; g < 4; g++) begin : g_mat
        load_channel #(.PAY_W(MAT_W), .IDX_W(IDX_W)) u_chan (
            .clk      (clk_clk),
            .rst_n    (reset_reset_n),
            .wr_en_i  (wr_en[g]),
            .auto_i   (cmd_auto_row),
            .row_i    (cmd_row),
            .pay_i    ({cmd_layer, cmd_data}),
            .pay_o    (mat_pay[g]),
            .row_o    (mat_row[g]),
            .strobe_o (mat_stb[g])
        );
    end

    // Code channel: row is the code line, payload is the low code bits.
    load_channel #(.PAY_W(CODE_W), .IDX_W(IDX_W)) u_code (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .wr_en_i  (wr_en[CH_C]),
        .auto_i   (cmd_auto_row),
        .row_i    (cmd_row),
        .pay_i    (cmd_data[CODE_W-1:0]),
        .pay_o    (code_write_data),
        .row_o    (code_write_line),
        .strobe_o (code_is_write)
    );

    assign w_wr_data   = mat_pay[0][DATA_W-1:0];
    assign w_wr_layer  = mat_pay[0][DATA_W +: IDX_W];
    assign w_wr_row    = mat_row[0];
    assign w_is_write  = mat_stb[0];
    assign i_wr_data   = mat_pay[1][DATA_W-1:0];
    assign i_wr_layer  = mat_pay[1][DATA_W +: IDX_W];
    assign i_wr_row    = mat_row[1];
    assign i_is_write  = mat_stb[1];
    assign l_wr_data   = mat_pay[2][DATA_W-1:0];
    assign l_wr_layer  = mat_pay[2][DATA_W +: IDX_W];
    assign l_wr_row    = mat_row[2];
    assign l_is_write  = mat_stb[2];
    assign u_dc_dw     = mat_pay[3][DATA_W-1:0];
    assign u_layer     = mat_pay[3][DATA_W +: IDX_W];
    assign u_row       = mat_row[3];
    assign u_is_update = mat_stb[3];

`ifdef LOADER_STATS_EN
    logic [IDX_W-1:0] stat_q [NUM_CH];
    logic             stat_clr;

    assign stat_clr = accept && (state_q == S_LOAD) && (op == OP_START);

    // Saturating per-channel op counters, cleared on START.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int k = 0; k < NUM_CH; k++) stat_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (stat_clr) begin
                    stat_q[k] <= '0;
                end else if (wr_en[k] && (stat_q[k] != '1)) begin
                    stat_q[k] <= stat_q[k] + IDX_W'(1);
                end
            end
        end
    end

    assign stat_w = stat_q[CH_W];
    assign stat_i = stat_q[CH_I];
    assign stat_l = stat_q[CH_L];
    assign stat_u = stat_q[CH_U];
    assign stat_c = stat_q[CH_C];
`endif

endmodule
